// File: rtl/tm_pkg.sv
// Shared definitions for the telemetry frame scheduler:
//   - default frame geometry, idle fill byte and header tag
//   - virtual-channel ids and FSM state encoding
//   - output byte payload struct and header helper
package tm_pkg;

   localparam int unsigned FRAME_LEN_DEF  = 220;
   localparam int unsigned GAP_CYCLES_DEF = 4;
   localparam int unsigned MAX_CONSEC_DEF = 4;
   localparam logic [7:0]  FILL_BYTE_DEF  = 8'h55;
   localparam logic [5:0]  HDR_TAG_DEF    = 6'b101000;

   localparam int unsigned VC_W = 2;
   localparam logic [VC_W-1:0] VC_RT   = 2'd0;
   localparam logic [VC_W-1:0] VC_ST   = 2'd1;
   localparam logic [VC_W-1:0] VC_IDLE = 2'd3;

   localparam int unsigned ST_W = 3;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ARB  = 3'd1;
   localparam logic [2:0] ST_HDR0 = 3'd2;
   localparam logic [2:0] ST_HDR1 = 3'd3;
   localparam logic [2:0] ST_DATA = 3'd4;
   localparam logic [2:0] ST_GAP  = 3'd5;

   // One byte beat towards the CRC appender
   typedef struct packed {
      logic       sof;
      logic       en;
      logic [7:0] data;
   } tmByte_t;

   // Header byte 0 carries the tag in the upper bits and the VC id below it
   function automatic logic [7:0] hdrByte0(input logic [5:0] tag, input logic [VC_W-1:0] vc);
      return {tag, vc};
   endfunction

endpackage

// File: rtl/tm_vc_arbiter.sv
// Frame-source arbiter.
//   Clk, Rst_n        : clock, async active-low reset
//   Req0, Req1        : VC0 / VC1 have a full frame buffered
//   Idle_En           : idle fill frames allowed
//   GrantStb          : high during the arbitration cycle; commits the decision
//   GrantVld_c        : a source is selected (combinational)
//   GrantVc_c         : selected VC id (combinational)
module tm_vc_arbiter
   import tm_pkg::*;
#(
   parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEF
)(
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Req0,
   input  logic            Req1,
   input  logic            Idle_En,
   input  logic            GrantStb,
   output logic            GrantVld_c,
   output logic [VC_W-1:0] GrantVc_c
);

   localparam int unsigned CONS_W = $clog2(MAX_CONSEC + 1);

   logic [CONS_W-1:0] consec;
   logic              atLimit_c;

   assign atLimit_c = (consec == CONS_W'(MAX_CONSEC));

   // VC0 has priority until it has used its back-to-back budget while VC1 waits
   always_comb begin
      GrantVld_c = 1'b1;
      GrantVc_c  = VC_RT;
      if (Req0 && !(Req1 && atLimit_c)) begin
         GrantVc_c = VC_RT;
      end else if (Req1) begin
         GrantVc_c = VC_ST;
      end else if (Idle_En) begin
         GrantVc_c = VC_IDLE;
      end else begin
         GrantVld_c = 1'b0;
      end
   end

   // Consecutive VC0 grant count, saturating; any other grant clears it
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         consec <= '0;
      end else if (GrantStb && GrantVld_c) begin
         if (GrantVc_c == VC_RT) begin
            if (!atLimit_c) consec <= consec + CONS_W'(1);
         end else begin
            consec <= '0;
         end
      end
   end

endmodule

// File: rtl/tm_frame_scheduler.sv
// Telemetry transfer-frame scheduler feeding the CRC appender.
//   ClkI_Dec8, Rst_n  : byte clock, async active-low reset
//   Sched_En, Idle_En : scheduler enable, idle-frame permit
//   Req0/Req1         : VC0/VC1 have a full payload buffered
//   DataI0/DataI1     : show-ahead FIFO head bytes
//   Rd0/Rd1           : FIFO pop strobes (combinational from state)
//   En_DataO, DataO   : registered byte stream to the appender
//   Sof               : registered pulse with header byte 0
//   Cur_Vc            : VC id of the current frame, held through the gap
//   Busy              : high whenever the FSM is out of IDLE
module tm_frame_scheduler
   import tm_pkg::*;
#(
   parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
   parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEF,
   parameter logic [7:0]  FILL_BYTE  = FILL_BYTE_DEF,
   parameter logic [5:0]  HDR_TAG    = HDR_TAG_DEF
)(
   input  logic       ClkI_Dec8,
   input  logic       Rst_n,
   input  logic       Sched_En,
   input  logic       Idle_En,
   input  logic       Req0,
   input  logic       Req1,
   input  logic [7:0] DataI0,
   input  logic [7:0] DataI1,
   output logic       Rd0,
   output logic       Rd1,
   output logic       En_DataO,
   output logic [7:0] DataO,
   output logic       Sof,
   output logic [1:0] Cur_Vc,
   output logic       Busy
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_LEN - 3);
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  nextState;
   logic [CNT_W-1:0] byteCnt;
   logic [GAP_W-1:0] gapCnt;
   logic [7:0]       frmCnt0;
   logic [7:0]       frmCnt1;
   logic [7:0]       frmCntIdle;
   logic [VC_W-1:0]  curVc;
   logic             busyQ;
   tmByte_t          outQ;

   logic             grantVld_c;
   logic [VC_W-1:0]  grantVc_c;
   logic             lastByte_c;
   logic [7:0]       dataSel_c;
   logic [7:0]       frmCntSel_c;

   tm_vc_arbiter #(
      .MAX_CONSEC (MAX_CONSEC)
   ) uArb (
      .Clk        (ClkI_Dec8),
      .Rst_n      (Rst_n),
      .Req0       (Req0),
      .Req1       (Req1),
      .Idle_En    (Idle_En),
      .GrantStb   (state == ST_ARB),
      .GrantVld_c (grantVld_c),
      .GrantVc_c  (grantVc_c)
   );

   assign lastByte_c = (byteCnt == LAST_BYTE);

   // Payload source and per-VC frame counter selection
   always_comb begin
      dataSel_c   = FILL_BYTE;
      frmCntSel_c = frmCntIdle;
      case (curVc)
         VC_RT: begin
            dataSel_c   = DataI0;
            frmCntSel_c = frmCnt0;
         end
         VC_ST: begin
            dataSel_c   = DataI1;
            frmCntSel_c = frmCnt1;
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge ClkI_Dec8 or negedge Rst_n) begin
      if (!Rst_n) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (Sched_En) nextState = ST_ARB;
         ST_ARB:  nextState = grantVld_c ? ST_HDR0 : ST_IDLE;
         ST_HDR0: nextState = ST_HDR1;
         ST_HDR1: nextState = ST_DATA;
         ST_DATA: if (lastByte_c) nextState = ST_GAP;
         ST_GAP:  if (gapCnt == '0) nextState = Sched_En ? ST_ARB : ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   // Payload byte counter and gap counter
   always_ff @(posedge ClkI_Dec8 or negedge Rst_n) begin
      if (!Rst_n) begin
         byteCnt <= '0;
         gapCnt  <= '0;
      end else begin
         case (state)
            ST_HDR1: byteCnt <= '0;
            ST_DATA: begin
               byteCnt <= byteCnt + CNT_W'(1);
               if (lastByte_c) gapCnt <= GAP_LOAD;
            end
            ST_GAP:  if (gapCnt != '0) gapCnt <= gapCnt - GAP_W'(1);
            default: ;
         endcase
      end
   end

   // Frame source latch and per-VC frame counters (bumped after header byte 1)
   always_ff @(posedge ClkI_Dec8 or negedge Rst_n) begin
      if (!Rst_n) begin
         curVc      <= VC_RT;
         frmCnt0    <= '0;
         frmCnt1    <= '0;
         frmCntIdle <= '0;
      end else begin
         if (state == ST_ARB && grantVld_c) curVc <= grantVc_c;
         if (state == ST_HDR1) begin
            case (curVc)
               VC_RT:   frmCnt0    <= frmCnt0 + 8'd1;
               VC_ST:   frmCnt1    <= frmCnt1 + 8'd1;
               default: frmCntIdle <= frmCntIdle + 8'd1;
            endcase
         end
      end
   end

   // Output byte register; Busy tracks the state being entered so it matches the state
   always_ff @(posedge ClkI_Dec8 or negedge Rst_n) begin
      if (!Rst_n) begin
         outQ  <= '0;
         busyQ <= 1'b0;
      end else begin
         outQ  <= '0;
         busyQ <= (nextState != ST_IDLE);
         case (state)
            ST_HDR0: begin
               outQ.sof  <= 1'b1;
               outQ.en   <= 1'b1;
               outQ.data <= hdrByte0(HDR_TAG, curVc);
            end
            ST_HDR1: begin
               outQ.en   <= 1'b1;
               outQ.data <= frmCntSel_c;
            end
            ST_DATA: begin
               outQ.en   <= 1'b1;
               outQ.data <= dataSel_c;
            end
            default: ;
         endcase
      end
   end

   assign Rd0      = (state == ST_DATA) && (curVc == VC_RT);
   assign Rd1      = (state == ST_DATA) && (curVc == VC_ST);
   assign En_DataO = outQ.en;
   assign DataO    = outQ.data;
   assign Sof      = outQ.sof;
   assign Cur_Vc   = curVc;
   assign Busy     = busyQ;

endmodule

// File: doc/tm_frame_scheduler.md
Name: tm_frame_scheduler

Overview:
- Sequences the telemetry CRC appender. Builds fixed-length 220-byte transfer frames from two virtual-channel (VC) sources, or from idle fill when neither source is ready.
- Prepends a 2-byte header to each frame.
- Drives the appender's byte-enable/data input and enforces the inter-frame gap the appender needs to emit its CRC tail and clear its byte counter.
- Sits between the VC buffers (show-ahead FIFOs) and the CRC appender, in the divided-by-8 clock domain.

Parameters:
- FRAME_LEN, 220: total bytes per frame delivered to the CRC appender (header plus payload).
- GAP_CYCLES, 4: minimum cycles En_DataO stays low between frames (3 CRC bytes plus 1 counter-clear cycle).
- MAX_CONSEC, 4: maximum back-to-back VC0 frames while VC1 is requesting.
- FILL_BYTE, 8'h55: payload byte used in idle frames.
- HDR_TAG, 6'b101000: upper 6 bits of header byte 0.

Ports:
- ClkI_Dec8  in  1  byte clock; all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Sched_En  in  1  scheduler enable, level.
- Idle_En  in  1  permit idle fill frames.
- Req0  in  1  VC0 (real-time) has at least FRAME_LEN-2 bytes buffered.
- Req1  in  1  VC1 (stored) has at least FRAME_LEN-2 bytes buffered.
- DataI0  in  8  VC0 show-ahead FIFO head byte.
- DataI1  in  8  VC1 show-ahead FIFO head byte.
- Rd0  out  1  VC0 pop strobe, combinational from state.
- Rd1  out  1  VC1 pop strobe, combinational from state.
- En_DataO  out  1  byte valid to CRC appender, registered.
- DataO  out  8  byte to CRC appender, registered.
- Sof  out  1  one-cycle pulse, coincident with header byte 0 on En_DataO.
- Cur_Vc  out  2  VC id of the frame in progress (0, 1, or 3 for idle); held through GAP.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Rst_n=0, asynchronous): state IDLE.
  - En_DataO=0, DataO=0, Sof=0, Cur_Vc=0, Busy=0, Rd0=Rd1=0.
  - Byte counter, gap counter, consecutive-VC0 counter and all three frame counters go to 0.
  - Reset mid-frame aborts the frame without completing it. The CRC appender shares the same reset.
- States: IDLE, ARB, HDR0, HDR1, DATA, GAP.
- IDLE -> ARB when Sched_En=1.
- ARB (one cycle) selects the next frame source:
  - VC0 if Req0=1 and not (Req1=1 and consec=MAX_CONSEC).
  - Otherwise VC1 if Req1=1.
  - Otherwise idle frame if Idle_En=1.
  - Otherwise return to IDLE.
  - The selection latches Cur_Vc.
  - consec counter: increments on a VC0 grant (saturates at MAX_CONSEC); clears on a VC1 or idle grant.
  - Req is sampled only in ARB; changes at any other time are ignored.
- HDR0 (1 cycle): next-edge DataO = {HDR_TAG, Cur_Vc}, En_DataO=1, Sof=1.
- HDR1 (1 cycle): next-edge DataO = frame counter of Cur_Vc, En_DataO=1. That counter then increments, wrapping 255 -> 0.
- DATA (FRAME_LEN-2 = 218 cycles):
  - For VC0/VC1: Rd of the selected VC is high every DATA cycle. DataO <= the selected DataI in the same cycle; En_DataO=1.
  - For an idle frame: no Rd; DataO <= FILL_BYTE.
  - After the last byte, go to GAP.
- En_DataO is high for exactly FRAME_LEN consecutive cycles per frame.
- Latency: the state-to-output delay is 1 cycle.
- GAP:
  - En_DataO=0 and DataO=0 for GAP_CYCLES cycles; the counter loads at GAP entry.
  - Then go to ARB if Sched_En=1, else IDLE.
  - Minimum frame period = FRAME_LEN + GAP_CYCLES + 1 (the ARB cycle) = 225 cycles.
- Sched_En dropping mid-frame: the current frame and its gap complete, then the scheduler goes to IDLE. A frame is never truncated.
- Source underflow (Req asserted while buffer empty) is a source contract violation. The scheduler still pops 218 times and is not required to detect it.
- Byte counter: 8 bits wide, compared against FRAME_LEN-2 - 1. No wrap occurs within a frame.

Decomposition:
- Shared package tm_pkg:
  - State encoding for tm_frame_scheduler.
  - VC id constants: VC_RT=0, VC_ST=1, VC_IDLE=3.
  - FRAME_LEN, GAP_CYCLES, HDR_TAG, FILL_BYTE defaults.
- One natural sub-module: tm_vc_arbiter.
  - Implements the ARB decision and the consec counter.
  - Inputs: Req0, Req1, Idle_En, grant strobe.
  - Outputs: grant valid and vc id.
- The FSM, counters and output registers stay in tm_frame_scheduler.

Test Plan:
- Reset, then Sched_En=1, Req0=1, Idle_En=0, VC0 FIFO bytes 0..217 -> En_DataO high 220 cycles; bytes A0, 00, 00..D9; Sof on the first byte; Rd0 high 218 cycles; then En_DataO low for 4 cycles.
- Req0=Req1=1 held continuously -> frame Cur_Vc sequence 0,0,0,0,1,0,0,0,0,1; VC0 frame counters 0..7, VC1 frame counters 0,1.
- Req0=Req1=0, Idle_En=1 -> frames with header A3, nn and 218 bytes of 55; Rd0=Rd1=0 throughout. With Idle_En=0 the FSM cycles ARB -> IDLE and En_DataO stays 0.
- 257 VC1 frames -> header byte 1 runs 00..FF then 00; frame period measured at 225 cycles.
- Sched_En dropped at DATA byte 100 -> frame completes all 220 bytes, gap of 4 cycles, Busy falls, no new Sof.
- Rst_n pulsed low at DATA byte 50 -> En_DataO, DataO, Rd0 go to 0 immediately; after release and re-request, the next frame header byte 1 is 00.
